// File: rtl/dpc_pkg.sv
// rtl/dpc_pkg.sv - shared sizes, FSM states and display encodings for the DPC sequencer
package dpc_pkg;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int IW    = 2;
    localparam int RES_W = 16;
    localparam int ACC_W = 2 * DW + IW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CLR,
        S_MAC,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        DISP_BLANK = 2'd0,
        DISP_A     = 2'd1,
        DISP_B     = 2'd2,
        DISP_RES   = 2'd3
    } disp_sel_t;

    function automatic logic [RES_W-1:0] zext_elem(input logic [DW-1:0] v);
        return {{(RES_W - DW){1'b0}}, v};
    endfunction
endpackage

// File: rtl/dpc_mac_controller_if.sv
// rtl/dpc_mac_controller_if.sv - register-file and multiplier bus between sequencer and datapath
interface dpc_mac_controller_if;
    import dpc_pkg::*;

    logic [IW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_we_a;
    logic            mem_we_b;
    logic [DW-1:0]   mem_rdata_a;
    logic [DW-1:0]   mem_rdata_b;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic [2*DW-1:0] mul_p;

    modport master (
        output mem_addr, mem_wdata, mem_we_a, mem_we_b, mul_a, mul_b,
        input  mem_rdata_a, mem_rdata_b, mul_p
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we_a, mem_we_b, mul_a, mul_b,
        output mem_rdata_a, mem_rdata_b, mul_p
    );
endinterface

// File: rtl/dpc_sync_edge.sv
// rtl/dpc_sync_edge.sv - 2-FF synchroniser with a rising-edge pulse on the AND of all its lines
module dpc_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_rise
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Multi-line instances report the moment all lines become high together
    assign o_q    = r_sync;
    assign o_rise = (&r_sync) & ~(&r_prev);
endmodule

// File: rtl/dpc_mac_controller.sv
// rtl/dpc_mac_controller.sv - switch-driven sequencer: element writes, element reads and N-cycle dot product
module dpc_mac_controller
    import dpc_pkg::*;
(
    input  logic                    clk,
    input  logic                    btnC,
    input  logic [DW-1:0]           sw_data,
    input  logic [IW-1:0]           sw_idx,
    input  logic                    we_a,
    input  logic                    we_b,
    input  logic                    re_a,
    input  logic                    re_b,
    dpc_mac_controller_if.master    mem,
    output logic [1:0]              disp_sel,
    output logic [RES_W-1:0]        disp_val,
    output logic                    ovf,
    output logic                    busy,
    output logic                    done
);
    logic [DW-1:0] w_data;
    logic [IW-1:0] w_idx;
    logic          w_we_a;
    logic          w_we_b;
    logic          w_we_a_rise;
    logic          w_we_b_rise;
    logic [1:0]    w_re;
    logic          w_rd_rise;
    logic          w_data_rise_unused;
    logic          w_idx_rise_unused;

    dpc_sync_edge #(.W(DW)) u_sync_data (.clk(clk), .rst(btnC), .i_d(sw_data), .o_q(w_data), .o_rise(w_data_rise_unused));
    dpc_sync_edge #(.W(IW)) u_sync_idx  (.clk(clk), .rst(btnC), .i_d(sw_idx),  .o_q(w_idx),  .o_rise(w_idx_rise_unused));
    dpc_sync_edge #(.W(1))  u_sync_we_a (.clk(clk), .rst(btnC), .i_d(we_a),    .o_q(w_we_a), .o_rise(w_we_a_rise));
    dpc_sync_edge #(.W(1))  u_sync_we_b (.clk(clk), .rst(btnC), .i_d(we_b),    .o_q(w_we_b), .o_rise(w_we_b_rise));
    dpc_sync_edge #(.W(2))  u_sync_re   (.clk(clk), .rst(btnC), .i_d({re_b, re_a}), .o_q(w_re), .o_rise(w_rd_rise));

    state_t           r_state;
    logic [IW-1:0]    r_k;
    logic [ACC_W-1:0] r_acc;
    logic [RES_W-1:0] r_result;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic             r_we_a;
    logic             r_we_b;
    logic [IW-1:0]    r_waddr;
    logic [DW-1:0]    r_wdata;
    disp_sel_t        r_disp_sel;
    logic [RES_W-1:0] r_disp_val;

    logic             w_mac;
    logic             w_rd_both;
    logic [ACC_W-1:0] w_acc_next;

    assign w_mac      = (r_state == S_MAC);
    assign w_rd_both  = &w_re;
    assign w_acc_next = r_acc + {{(ACC_W - 2 * DW){1'b0}}, mem.mul_p};

    // Address is shared: MAC walks k, a pending strobe owns its captured index, otherwise track the switches
    assign mem.mem_addr  = w_mac ? r_k : ((r_we_a | r_we_b) ? r_waddr : w_idx);
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_we_a  = r_we_a;
    assign mem.mem_we_b  = r_we_b;
    assign mem.mul_a     = w_mac ? mem.mem_rdata_a : '0;
    assign mem.mul_b     = w_mac ? mem.mem_rdata_b : '0;

    assign disp_sel = r_disp_sel;
    assign disp_val = r_disp_val;
    assign ovf      = r_ovf;
    assign busy     = r_busy;
    assign done     = r_done;

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_we_a     <= 1'b0;
            r_we_b     <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_disp_sel <= DISP_BLANK;
            r_disp_val <= '0;
        end else begin
            r_we_a <= 1'b0;
            r_we_b <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_RD_A, S_RD_B: begin
                    if (w_we_a_rise | w_we_b_rise) begin
                        r_we_a  <= w_we_a_rise;
                        r_we_b  <= w_we_b_rise;
                        r_waddr <= w_idx;
                        r_wdata <= w_data;
                    end
                    if (w_rd_rise) begin
                        r_state    <= S_CLR;
                        r_busy     <= 1'b1;
                        r_disp_sel <= DISP_RES;
                        r_disp_val <= r_result;
                    end else if (w_re[0] & ~w_re[1]) begin
                        r_state    <= S_RD_A;
                        r_disp_sel <= DISP_A;
                        r_disp_val <= zext_elem(mem.mem_rdata_a);
                    end else if (~w_re[0] & w_re[1]) begin
                        r_state    <= S_RD_B;
                        r_disp_sel <= DISP_B;
                        r_disp_val <= zext_elem(mem.mem_rdata_b);
                    end else begin
                        r_state    <= S_IDLE;
                        r_disp_sel <= DISP_BLANK;
                        r_disp_val <= '0;
                    end
                end
                S_CLR, S_MAC: begin
                    if (!w_rd_both) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_disp_sel <= DISP_BLANK;
                        r_disp_val <= '0;
                    end else if (r_state == S_CLR) begin
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= S_MAC;
                    end else begin
                        r_acc <= w_acc_next;
                        r_k   <= r_k + 1'b1;
                        // Last product is folded in directly so done lands N+2 cycles after the edge
                        if (r_k == IW'(N - 1)) begin
                            r_result   <= w_acc_next[RES_W-1:0];
                            r_ovf      <= |w_acc_next[ACC_W-1:RES_W];
                            r_disp_val <= w_acc_next[RES_W-1:0];
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_rd_both) begin
                        r_state    <= S_IDLE;
                        r_disp_sel <= DISP_BLANK;
                        r_disp_val <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_sync_level_unused;
    assign w_sync_level_unused = w_we_a ^ w_we_b;
endmodule
